// File: rtl/clip_record_play_controller_if.sv
// Memory-side datapath bundle between the clip sequencer and the
// serializer / deserializer / sample memory.
interface clip_record_play_controller_if #(
    parameter int NUM_CLIPS = 4,
    parameter int ADDR_W    = 17
);
    localparam int SEL_W = $clog2(NUM_CLIPS);

    logic              ser_en;    // serializer enable while recording
    logic              deser_en;  // deserializer enable while playing
    logic [ADDR_W-1:0] mem_addr;  // sample address within the active bank
    logic              mem_rw;    // 1 write, 0 read
    logic              mem_we;    // write strobe
    logic [SEL_W-1:0]  mem_bank;  // active bank

    modport master (output ser_en, deser_en, mem_addr, mem_rw, mem_we, mem_bank);
    modport slave  (input  ser_en, deser_en, mem_addr, mem_rw, mem_we, mem_bank);
endinterface

// File: rtl/clip_record_play_controller.sv
// Record/playback sequencer for NUM_CLIPS clips sharing one sample memory.
// Each clip keeps its recorded length so playback stops at the recorded end.
// Optional feature: define LOOP_PLAYBACK_EN to make playback wrap to address 0
// at the end of the clip instead of finishing; only stop ends a looping play.
module clip_record_play_controller #(
    parameter int NUM_CLIPS = 4,
    parameter int ADDR_W    = 17,
    parameter int MAX_LEN   = 2**ADDR_W,
    localparam int SEL_W    = $clog2(NUM_CLIPS)
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 play_cmd_i,
    input  logic                 record_cmd_i,
    input  logic                 stop_cmd_i,
    input  logic [SEL_W-1:0]     clip_sel_i,
    input  logic                 sample_tick_i,
    output logic [3:0]           clip_num_o,
    output logic                 busy_o,
    output logic [1:0]           state_o,
    output logic [NUM_CLIPS-1:0] clip_valid_o,
    output logic                 done_o,
    clip_record_play_controller_if.master mem_if
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_REC  = 2'd2
    } state_e;

    // Lengths are one bit wider than the address so a full bank (MAX_LEN) fits.
    localparam logic [ADDR_W:0] MAX_LEN_W = (ADDR_W+1)'(MAX_LEN);

    state_e                          state_q, state_d;
    logic [SEL_W-1:0]                bank_q, bank_d;
    logic [ADDR_W-1:0]               addr_q, addr_d;
    logic [NUM_CLIPS-1:0][ADDR_W:0]  len_q, len_d;
    logic                            done_q, done_d;
    logic [ADDR_W:0]                 addr_inc;

    // Full-width address + 1: doubles as "samples done after this tick".
    assign addr_inc = {1'b0, addr_q} + 1'b1;

    // State, bank, address, lengths and done pulse registers.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= S_IDLE;
            bank_q  <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bank_q  <= bank_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            done_q  <= done_d;
        end
    end

    // Next-state: command decode in IDLE, sample stepping and end detection otherwise.
    always_comb begin
        state_d = state_q;
        bank_d  = bank_q;
        addr_d  = addr_q;
        len_d   = len_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                // stop in IDLE is a no-op but still outranks record/play
                if (stop_cmd_i) begin
                    state_d = S_IDLE;
                end else if (record_cmd_i) begin
                    state_d           = S_REC;
                    bank_d            = clip_sel_i;
                    len_d[clip_sel_i] = '0;  // an aborted take never replays stale data
                end else if (play_cmd_i && (len_q[clip_sel_i] != '0)) begin
                    state_d = S_PLAY;
                    bank_d  = clip_sel_i;
                end
            end
            S_REC: begin
                if (sample_tick_i && (addr_inc == MAX_LEN_W)) begin
                    len_d[bank_q] = MAX_LEN_W;
                    state_d       = S_IDLE;
                    done_d        = 1'b1;
                end else if (stop_cmd_i) begin
                    // a tick coinciding with stop has already been written
                    len_d[bank_q] = sample_tick_i ? addr_inc : {1'b0, addr_q};
                    state_d       = S_IDLE;
                    done_d        = 1'b1;
                end else if (sample_tick_i) begin
                    addr_d = addr_inc[ADDR_W-1:0];
                end
            end
            S_PLAY: begin
                if (stop_cmd_i) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else if (sample_tick_i) begin
                    if (addr_inc == len_q[bank_q]) begin
`ifdef LOOP_PLAYBACK_EN
                        addr_d = '0;
`else
                        state_d = S_IDLE;
                        done_d  = 1'b1;
`endif
                    end else begin
                        addr_d = addr_inc[ADDR_W-1:0];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Entering any state from IDLE, or returning to IDLE, restarts the address.
        if (state_d == S_IDLE || state_q == S_IDLE) addr_d = '0;
    end

    // A clip is valid once it holds at least one sample.
    always_comb begin
        clip_valid_o = '0;
        for (int i = 0; i < NUM_CLIPS; i++) clip_valid_o[i] = (len_q[i] != '0);
    end

    // LED clip number follows the selector in IDLE and the latched bank otherwise;
    // forced to 0 while reset is asserted.
    always_comb begin
        clip_num_o = '0;
        if (reset_i)
            clip_num_o = (state_q == S_IDLE) ? 4'(clip_sel_i) + 4'd1 : 4'(bank_q) + 4'd1;
    end

    assign busy_o          = (state_q != S_IDLE);
    assign state_o         = state_q;
    assign done_o          = done_q;
    assign mem_if.ser_en   = (state_q == S_REC);
    assign mem_if.deser_en = (state_q == S_PLAY);
    assign mem_if.mem_rw   = (state_q == S_REC);
    assign mem_if.mem_we   = (state_q == S_REC) && sample_tick_i;
    assign mem_if.mem_addr = addr_q;
    assign mem_if.mem_bank = bank_q;
endmodule

// File: tb/tb_clip_record_play_controller.sv
// Directed bench: memory accesses are predicted into a scoreboard when ticks
// are driven and checked by a monitor when the DUT performs them.
module tb_clip_record_play_controller;
    localparam int NUM_CLIPS = 4;
    localparam int ADDR_W    = 3;
    localparam int MAX_LEN   = 8;

    typedef struct packed {
        logic       rw;
        logic [1:0] bank;
        logic [2:0] addr;
    } acc_t;

    logic       clock_i = 1'b0;
    logic       reset_i = 1'b0;
    logic       play_cmd_i = 1'b0, record_cmd_i = 1'b0, stop_cmd_i = 1'b0;
    logic [1:0] clip_sel_i = 2'd0;
    logic       sample_tick_i = 1'b0;
    logic [3:0] clip_num_o;
    logic       busy_o, done_o;
    logic [1:0] state_o;
    logic [3:0] clip_valid_o;

    int checks = 0;
    int errors = 0;
    acc_t exp_q[$];

    clip_record_play_controller_if #(.NUM_CLIPS(NUM_CLIPS), .ADDR_W(ADDR_W)) mi ();

    clip_record_play_controller #(.NUM_CLIPS(NUM_CLIPS), .ADDR_W(ADDR_W), .MAX_LEN(MAX_LEN)) dut (
        .clock_i(clock_i), .reset_i(reset_i),
        .play_cmd_i(play_cmd_i), .record_cmd_i(record_cmd_i), .stop_cmd_i(stop_cmd_i),
        .clip_sel_i(clip_sel_i), .sample_tick_i(sample_tick_i),
        .clip_num_o(clip_num_o), .busy_o(busy_o), .state_o(state_o),
        .clip_valid_o(clip_valid_o), .done_o(done_o), .mem_if(mi.master)
    );

    always #5 clock_i = ~clock_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: inputs set before the call are seen by this edge, pulses clear after it.
    task automatic cyc();
        @(posedge clock_i);
        #1;
        play_cmd_i = 1'b0; record_cmd_i = 1'b0; stop_cmd_i = 1'b0; sample_tick_i = 1'b0;
    endtask

    // Scoreboard monitor: every write strobe or ticked read must match the next prediction.
    always @(negedge clock_i) begin
        if (reset_i && (mi.mem_we || (mi.deser_en && sample_tick_i))) begin
            if (exp_q.size() == 0) chk("unexpected_access", 32'(mi.mem_addr), 32'hFFFF);
            else chk("mem_access", 32'({mi.mem_rw, mi.mem_bank, mi.mem_addr}), 32'(exp_q.pop_front()));
        end
    end

    task automatic record_clip(input int sel, input int nticks);
        clip_sel_i = 2'(sel); record_cmd_i = 1'b1; cyc();
        chk("rec_entry_state", 32'(state_o), 32'd2);
        chk("rec_entry_addr", 32'(mi.mem_addr), 32'd0);
        for (int i = 0; i < nticks; i++) begin
            exp_q.push_back('{rw: 1'b1, bank: 2'(sel), addr: 3'(i)});
            sample_tick_i = 1'b1; cyc();
        end
    endtask

    // Play a clip of length len; in loop builds run past the end and then stop.
    task automatic play_clip(input int sel, input int len);
        int n;
`ifdef LOOP_PLAYBACK_EN
        n = 2 * len + 1;
`else
        n = len;
`endif
        for (int i = 0; i < n; i++) exp_q.push_back('{rw: 1'b0, bank: 2'(sel), addr: 3'(i % len)});
        clip_sel_i = 2'(sel); play_cmd_i = 1'b1; cyc();
        chk("play_entry", 32'({state_o, mi.deser_en, mi.mem_rw, mi.mem_addr}), {27'd0, 2'd1, 1'b1, 1'b0, 3'd0});
        for (int i = 0; i < n; i++) begin
            sample_tick_i = 1'b1; cyc();
            if (i < n - 1) chk("play_step", 32'({state_o, done_o, mi.mem_addr}), {26'd0, 2'd1, 1'b0, 3'((i + 1) % len)});
        end
`ifdef LOOP_PLAYBACK_EN
        chk("loop_no_done", 32'({state_o, done_o, mi.mem_addr}), {26'd0, 2'd1, 1'b0, 3'(n % len)});
        stop_cmd_i = 1'b1; cyc();
`endif
        chk("play_end", 32'({state_o, done_o, mi.deser_en, mi.mem_addr}), {25'd0, 2'd0, 1'b1, 1'b0, 3'd0});
    endtask

    initial begin
        // Reset held low while commands toggle
        for (int i = 0; i < 4; i++) begin
            play_cmd_i = i[0]; record_cmd_i = ~i[0]; stop_cmd_i = i[1]; sample_tick_i = 1'b1;
            clip_sel_i = 2'(i);
            @(posedge clock_i); #1;
            chk("reset_outputs", {state_o, busy_o, done_o, clip_num_o, clip_valid_o,
                 mi.ser_en, mi.deser_en, mi.mem_rw, mi.mem_we, mi.mem_bank, mi.mem_addr, 12'd0}, 32'd0);
        end
        play_cmd_i = 0; record_cmd_i = 0; stop_cmd_i = 0; sample_tick_i = 0;
        clip_sel_i = 2'd1; reset_i = 1'b1; cyc();
        chk("idle_clip_num", 32'(clip_num_o), 32'd2);

        // Full-length record of clip 1, selector moved mid-take, gap cycles between ticks
        clip_sel_i = 2'd1; record_cmd_i = 1'b1; cyc();
        chk("rec_state", 32'({state_o, mi.ser_en, mi.mem_rw, mi.mem_bank}), {26'd0, 2'd2, 1'b1, 1'b1, 2'd1});
        clip_sel_i = 2'd3;
        for (int i = 0; i < MAX_LEN; i++) begin
            exp_q.push_back('{rw: 1'b1, bank: 2'd1, addr: 3'(i)});
            sample_tick_i = 1'b1; cyc();
            if (i < MAX_LEN - 1) begin
                chk("rec_step", 32'({state_o, done_o, mi.mem_bank, mi.mem_addr}), {24'd0, 2'd2, 1'b0, 2'd1, 3'(i + 1)});
                chk("rec_clip_num", 32'(clip_num_o), 32'd2);
                cyc();
            end
        end
        chk("rec_full_end", 32'({state_o, done_o, mi.ser_en, mi.mem_rw, mi.mem_addr}), {25'd0, 2'd0, 1'b1, 1'b0, 1'b0, 3'd0});
        chk("valid_after_full", 32'(clip_valid_o), 32'b0010);
        cyc();
        chk("done_one_cycle", 32'(done_o), 32'd0);

        // Clip 0: one tick, then stop together with a tick -> length 2
        record_clip(0, 1);
        exp_q.push_back('{rw: 1'b1, bank: 2'd0, addr: 3'd1});
        sample_tick_i = 1'b1; stop_cmd_i = 1'b1; cyc();
        chk("rec_stop_tick", 32'({state_o, done_o, clip_valid_o}), {25'd0, 2'd0, 1'b1, 4'b0011});

        // Clip 2: three ticks then stop -> length 3
        record_clip(2, 3);
        stop_cmd_i = 1'b1; cyc();
        chk("rec_stop", 32'({state_o, done_o, mi.mem_addr, clip_valid_o}), {22'd0, 2'd0, 1'b1, 3'd0, 4'b0111});

        play_clip(0, 2);
        play_clip(2, 3);

        // Stop during playback at address 2
        exp_q.push_back('{rw: 1'b0, bank: 2'd2, addr: 3'd0});
        exp_q.push_back('{rw: 1'b0, bank: 2'd2, addr: 3'd1});
        clip_sel_i = 2'd2; play_cmd_i = 1'b1; cyc();
        sample_tick_i = 1'b1; cyc();
        sample_tick_i = 1'b1; cyc();
        chk("play_addr2", 32'({state_o, mi.mem_addr}), {27'd0, 2'd1, 3'd2});
        stop_cmd_i = 1'b1; cyc();
        chk("play_stop", 32'({state_o, done_o, mi.deser_en, mi.mem_addr}), {25'd0, 2'd0, 1'b1, 1'b0, 3'd0});

        // Empty clip 3 cannot be played
        clip_sel_i = 2'd3; play_cmd_i = 1'b1; cyc();
        chk("play_empty", 32'({state_o, busy_o, mi.deser_en, clip_num_o}), {24'd0, 2'd0, 1'b0, 1'b0, 4'd4});

        // Stop outranks record in IDLE
        stop_cmd_i = 1'b1; record_cmd_i = 1'b1; cyc();
        chk("stop_beats_rec", 32'(state_o), 32'd0);

        // Record outranks play; entering REC zeroes clip 1, immediate stop keeps it empty
        clip_sel_i = 2'd1; play_cmd_i = 1'b1; record_cmd_i = 1'b1; cyc();
        chk("rec_beats_play", 32'({state_o, clip_valid_o}), {26'd0, 2'd2, 4'b0101});
        stop_cmd_i = 1'b1; cyc();
        chk("rec_stop_empty", 32'({state_o, done_o, clip_valid_o}), {25'd0, 2'd0, 1'b1, 4'b0101});
        play_cmd_i = 1'b1; cyc();
        chk("play_aborted", 32'(state_o), 32'd0);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
